// File: rtl/sdp_ram_be_pipe.sv
`default_nettype none
// ============================================================================
// Module : sdp_ram_be_pipe
// Simple dual-port RAM with byte-enable writes, a 1- or 2-cycle read pipeline,
// selectable collision mode and an optional post-reset clear sweep.
// Rev    : 1.0
// ============================================================================
module sdp_ram_be_pipe #(
  parameter int DATA_W         = 32,
  parameter int ADDR_W         = 10,
  parameter int READ_LATENCY   = 1,
  parameter int WRITE_FIRST    = 0,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_wena,
  input  logic [DATA_W/8-1:0] i_wbea,
  input  logic [ADDR_W-1:0]   i_addra,
  input  logic [DATA_W-1:0]   i_dina,
  input  logic                i_renb,
  input  logic [ADDR_W-1:0]   i_addrb,
  output logic [DATA_W-1:0]   o_doutb,
  output logic                o_rvalidb,
  output logic                o_init_busy
);

  localparam int              c_NB    = DATA_W / 8;
  localparam int              c_DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W:0] c_LAST  = {1'b0, {ADDR_W{1'b1}}};
  localparam logic [ADDR_W:0] c_ONE   = {{ADDR_W{1'b0}}, 1'b1};

  typedef enum logic [0:0] {
    S_INIT  = 1'b0,
    S_READY = 1'b1
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [ADDR_W:0]     r_cnt;
  logic [DATA_W-1:0]   r_mem [c_DEPTH];
  logic [DATA_W-1:0]   r_rd1;
  logic                r_v1;
  logic                w_init;
  logic                w_wr;
  logic                w_rd;
  logic                w_collide;
  logic [DATA_W-1:0]   w_old;
  logic [DATA_W-1:0]   w_merged;
  logic [DATA_W-1:0]   w_rd_data;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= (CLEAR_ON_RESET != 0) ? S_INIT : S_READY;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_init) r_cnt <= r_cnt + c_ONE;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_init      = 1'b0;
    if (r_state == S_INIT) begin
      w_init = 1'b1;
      if (r_cnt == c_LAST) w_state_nxt = S_READY;
    end
  end

  assign o_init_busy = (r_state == S_INIT);
  assign w_wr        = i_wena & (r_state == S_READY);
  assign w_rd        = i_renb & (r_state == S_READY);

  // Storage has no reset; the sweep owns the write port while it runs.
  always_ff @(posedge clk) begin
    if (w_init) begin
      r_mem[r_cnt[ADDR_W-1:0]] <= '0;
    end else if (w_wr) begin
      for (int i = 0; i < c_NB; i++)
        if (i_wbea[i]) r_mem[i_addra][8*i +: 8] <= i_dina[8*i +: 8];
    end
  end

  always_comb begin
    w_old    = r_mem[i_addrb];
    w_merged = w_old;
    for (int i = 0; i < c_NB; i++)
      if (i_wbea[i]) w_merged[8*i +: 8] = i_dina[8*i +: 8];
    w_collide = w_wr & (i_addra == i_addrb);
    w_rd_data = ((WRITE_FIRST != 0) && w_collide) ? w_merged : w_old;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rd1 <= '0;
      r_v1  <= 1'b0;
    end else begin
      r_v1 <= w_rd;
      if (w_rd) r_rd1 <= w_rd_data;
    end
  end

  generate
    if (READ_LATENCY == 2) begin : g_lat2
      logic [DATA_W-1:0] r_rd2;
      logic              r_v2;
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_rd2 <= '0;
          r_v2  <= 1'b0;
        end else begin
          r_v2 <= r_v1;
          if (r_v1) r_rd2 <= r_rd1;
        end
      end
      assign o_doutb   = r_rd2;
      assign o_rvalidb = r_v2;
    end else begin : g_lat1
      assign o_doutb   = r_rd1;
      assign o_rvalidb = r_v1;
    end
  endgenerate

endmodule
`default_nettype wire

// File: tb/tb_sdp_ram_be_pipe.sv
`default_nettype none
// ============================================================================
// Module : tb_sdp_ram_be_pipe
// Directed bench: u_dut1 latency 1 read-first, u_dut2 latency 2 write-first,
// u_dut3 without clear sweep; all share one stimulus stream.
// Rev    : 1.0
// ============================================================================
module tb_sdp_ram_be_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        wena;
  logic [3:0]  wbea;
  logic [9:0]  addra;
  logic [31:0] dina;
  logic        renb;
  logic [9:0]  addrb;
  logic [31:0] d1, d2, d3;
  logic        v1, v2, v3;
  logic        b1, b2, b3;

  int   n_tests = 0;
  int   n_fail  = 0;
  int   n;
  logic saw_v;
  logic v3_first;

  always #5 clk = ~clk;

  sdp_ram_be_pipe #(.DATA_W(32), .ADDR_W(10), .READ_LATENCY(1), .WRITE_FIRST(0), .CLEAR_ON_RESET(1)) u_dut1 (
    .clk(clk), .rst(rst), .i_wena(wena), .i_wbea(wbea), .i_addra(addra), .i_dina(dina),
    .i_renb(renb), .i_addrb(addrb), .o_doutb(d1), .o_rvalidb(v1), .o_init_busy(b1));

  sdp_ram_be_pipe #(.DATA_W(32), .ADDR_W(10), .READ_LATENCY(2), .WRITE_FIRST(1), .CLEAR_ON_RESET(1)) u_dut2 (
    .clk(clk), .rst(rst), .i_wena(wena), .i_wbea(wbea), .i_addra(addra), .i_dina(dina),
    .i_renb(renb), .i_addrb(addrb), .o_doutb(d2), .o_rvalidb(v2), .o_init_busy(b2));

  sdp_ram_be_pipe #(.DATA_W(32), .ADDR_W(10), .READ_LATENCY(1), .WRITE_FIRST(0), .CLEAR_ON_RESET(0)) u_dut3 (
    .clk(clk), .rst(rst), .i_wena(wena), .i_wbea(wbea), .i_addra(addra), .i_dina(dina),
    .i_renb(renb), .i_addrb(addrb), .o_doutb(d3), .o_rvalidb(v3), .o_init_busy(b3));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [9:0] a, input logic [31:0] d, input logic [3:0] be);
    wena  = 1'b1;
    addra = a;
    dina  = d;
    wbea  = be;
    tick();
    wena  = 1'b0;
  endtask

  // Counts cycles until u_dut1 leaves INIT, noting any valid strobe on the way.
  task automatic wait_init(output int cycles);
    cycles = 0;
    while (b1 && cycles < 2000) begin
      tick();
      cycles++;
      if (v1 | v2) saw_v = 1'b1;
    end
  endtask

  initial begin
    rst = 1'b1; wena = 1'b0; wbea = '0; addra = '0; dina = '0; renb = 1'b0; addrb = '0;
    repeat (3) tick();
    check("rst_dout1", d1, 32'h0);
    check("rst_rv1", {31'b0, v1}, 32'h0);
    check("rst_rv2", {31'b0, v2}, 32'h0);
    check("rst_busy1", {31'b0, b1}, 32'h1);
    check("rst_busy3", {31'b0, b3}, 32'h0);

    // Requests issued throughout the first sweep must be dropped.
    wena = 1'b1; addra = 10'd5; dina = 32'hDEADBEEF; wbea = 4'hF;
    renb = 1'b1; addrb = 10'd5;
    rst = 1'b0;
    saw_v = 1'b0;
    tick();
    n = 1;
    v3_first = v3;
    if (v1 | v2) saw_v = 1'b1;
    while (b1 && n < 2000) begin
      tick();
      n++;
      if (v1 | v2) saw_v = 1'b1;
    end
    wena = 1'b0; renb = 1'b0;
    check("busy_len", n, 32'd1024);
    check("busy2_done", {31'b0, b2}, 32'h0);
    check("init_no_valid", {31'b0, saw_v}, 32'h0);
    check("dut3_ready_direct", {31'b0, v3_first}, 32'h1);
    tick();
    check("init_no_late_valid", {30'b0, v1, v2}, 32'h0);

    // Cleared words read back as zero.
    renb = 1'b1; addrb = 10'd0; tick();
    check("clr0_rv1", {31'b0, v1}, 32'h1);
    check("clr0_d1", d1, 32'h0);
    addrb = 10'd5; tick();
    check("clr5_d1", d1, 32'h0);
    check("clr0_rv2", {31'b0, v2}, 32'h1);
    check("clr0_d2", d2, 32'h0);
    check("dut3_write_kept", d3, 32'hDEADBEEF);
    addrb = 10'd1023; tick();
    check("clr1023_rv1", {31'b0, v1}, 32'h1);
    check("clr1023_d1", d1, 32'h0);
    renb = 1'b0; tick();
    check("idle_rv1", {31'b0, v1}, 32'h0);
    check("clr1023_rv2", {31'b0, v2}, 32'h1);
    tick();
    check("idle_rv2", {31'b0, v2}, 32'h0);

    // Full-word writes then back-to-back reads.
    wr(10'd5, 32'd350, 4'hF);
    wr(10'd7, 32'd670, 4'hF);
    renb = 1'b1; addrb = 10'd5; tick();
    check("rd5_rv1", {31'b0, v1}, 32'h1);
    check("rd5_d1", d1, 32'd350);
    addrb = 10'd7; tick();
    check("rd7_rv1", {31'b0, v1}, 32'h1);
    check("rd7_d1", d1, 32'd670);
    check("rd5_d2", d2, 32'd350);
    renb = 1'b0; tick();
    check("rd_end_rv1", {31'b0, v1}, 32'h0);
    check("hold_d1", d1, 32'd670);
    check("rd7_d2", d2, 32'd670);
    check("rd7_rv2", {31'b0, v2}, 32'h1);
    tick();
    check("rd_end_rv2", {31'b0, v2}, 32'h0);
    check("hold_d2", d2, 32'd670);

    // Byte-enable merge; read issued the cycle right after the write.
    wr(10'd5, 32'h11223344, 4'hF);
    wr(10'd5, 32'hAABBCCDD, 4'b0101);
    renb = 1'b1; addrb = 10'd5; tick(); renb = 1'b0;
    check("be_d1", d1, 32'h11BB33DD);
    tick();
    check("be_d2", d2, 32'h11BB33DD);
    wr(10'd5, 32'hFFFFFFFF, 4'h0);
    renb = 1'b1; tick(); renb = 1'b0;
    check("be0_noop", d1, 32'h11BB33DD);
    tick();

    // Same-address collisions.
    wr(10'd5, 32'd350, 4'hF);
    wena = 1'b1; addra = 10'd5; dina = 32'd961; wbea = 4'hF;
    renb = 1'b1; addrb = 10'd5; tick(); wena = 1'b0; renb = 1'b0;
    check("coll_read_first", d1, 32'd350);
    tick();
    check("coll_write_first", d2, 32'd961);
    renb = 1'b1; tick(); renb = 1'b0;
    check("coll_after", d1, 32'd961);
    tick();
    wena = 1'b1; dina = 32'hAABBCCDD; wbea = 4'b0011; renb = 1'b1; tick();
    wena = 1'b0; renb = 1'b0;
    check("coll_rf_partial", d1, 32'h000003C1);
    tick();
    check("coll_wf_merged", d2, 32'h0000CCDD);

    // Latency-2 pipeline, three consecutive reads.
    wr(10'd1, 32'h101, 4'hF);
    wr(10'd2, 32'h202, 4'hF);
    wr(10'd3, 32'h303, 4'hF);
    wr(10'd0, 32'h5A5A5A5A, 4'hF);
    wr(10'd1023, 32'hA5A5A5A5, 4'hF);
    renb = 1'b1; addrb = 10'd1; tick();
    check("l2_n1_rv2", {31'b0, v2}, 32'h0);
    addrb = 10'd2; tick();
    check("l2_n2_rv2", {31'b0, v2}, 32'h1);
    check("l2_n2_d2", d2, 32'h101);
    addrb = 10'd3; tick();
    check("l2_n3_d2", d2, 32'h202);
    renb = 1'b0; tick();
    check("l2_n4_rv2", {31'b0, v2}, 32'h1);
    check("l2_n4_d2", d2, 32'h303);
    tick();
    check("l2_n5_rv2", {31'b0, v2}, 32'h0);

    // Reset with reads in flight.
    renb = 1'b1; addrb = 10'd1; tick(); renb = 1'b0;
    check("pre_rst_d1", d1, 32'h101);
    rst = 1'b1; #1;
    check("mid_rst_rv1", {31'b0, v1}, 32'h0);
    check("mid_rst_d1", d1, 32'h0);
    check("mid_rst_rv2", {31'b0, v2}, 32'h0);
    check("mid_rst_d2", d2, 32'h0);
    check("mid_rst_busy", {31'b0, b1}, 32'h1);
    tick();

    // Sweep interrupted at count 300, with requests pending all along.
    wena = 1'b1; addra = 10'd7; dina = 32'h77; wbea = 4'hF;
    renb = 1'b1; addrb = 10'd7;
    rst = 1'b0;
    saw_v = 1'b0;
    repeat (300) begin
      tick();
      if (v1 | v2) saw_v = 1'b1;
    end
    check("sweep300_busy", {31'b0, b1}, 32'h1);
    rst = 1'b1; tick(); rst = 1'b0;
    wait_init(n);
    wena = 1'b0; renb = 1'b0;
    check("restart_len", n, 32'd1024);
    check("restart_no_valid", {31'b0, saw_v}, 32'h0);
    tick();
    check("restart_no_late", {30'b0, v1, v2}, 32'h0);

    renb = 1'b1; addrb = 10'd0; tick();
    check("reclr0_d1", d1, 32'h0);
    addrb = 10'd1023; tick();
    check("reclr1023_d1", d1, 32'h0);
    addrb = 10'd7; tick();
    check("init_wr_dropped", d1, 32'h0);
    renb = 1'b0; tick();
    check("final_rv1", {31'b0, v1}, 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/sdp_ram_be_pipe.md
Name: sdp_ram_be_pipe

Overview:
- Parametrised next-generation simple dual-port RAM: port A write-only, port B read-only, one shared clock.
- Adds byte-enable writes, selectable read latency (1 or 2), selectable read/write collision mode, a read-valid strobe, and an optional post-reset clear sweep.
- Drop-in storage primitive for datapath buffers and lookup tables.

Parameters:
- DATA_W, 32, word width in bits; must be a multiple of 8.
- ADDR_W, 10, address width; DEPTH = 2**ADDR_W words.
- READ_LATENCY, 1, cycles from renb sampled to doutb/rvalidb; legal values 1 or 2.
- WRITE_FIRST, 0, collision mode: 0 = read-first (old data), 1 = write-first (new data, byte-merged).
- CLEAR_ON_RESET, 1, 1 = zero every word after reset release; 0 = contents untouched by reset.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- wena  in  1  port A write enable.
- wbea  in  DATA_W/8  port A byte enables; bit i selects dina[8i+7:8i].
- addra  in  ADDR_W  port A write address.
- dina  in  DATA_W  port A write data.
- renb  in  1  port B read enable.
- addrb  in  ADDR_W  port B read address.
- doutb  out  DATA_W  port B read data.
- rvalidb  out  1  doutb carries data for a read issued READ_LATENCY cycles earlier.
- init_busy  out  1  clear sweep in progress; port A and port B requests are ignored.

Behaviour:
- Reset (rst=1, asynchronous):
  - doutb=0, rvalidb=0, all pipeline registers cleared.
  - init_busy = CLEAR_ON_RESET.
  - Sweep counter = 0.
  - Memory array is not reset directly.
- FSM states:
  - INIT: entered on reset only when CLEAR_ON_RESET=1. Writes 0 to word[cnt] each cycle and increments cnt. Leaves to READY on the edge that writes word DEPTH-1, so init_busy is high for exactly DEPTH cycles after rst falls.
  - READY: normal operation.
  - With CLEAR_ON_RESET=0, the block enters READY directly and init_busy stays 0.
- Reset asserted mid-sweep or mid-read: asynchronous clear as above; the sweep restarts at address 0; in-flight reads are discarded and produce no rvalidb.
- Requests in INIT: wena and renb are dropped silently; no rvalidb is produced for them.
- Write (READY, wena=1): on the clock edge, word[addra] byte i <= dina byte i for every i with wbea[i]=1; other bytes are unchanged. wbea=0 with wena=1 is a no-op.
- Read (READY, renb=1):
  - READ_LATENCY=1: doutb = word[addrb] and rvalidb=1 after the next edge.
  - READ_LATENCY=2: data passes through one extra output register and appears one cycle later.
  - Back-to-back reads are fully pipelined, one per cycle.
- No read: rvalidb=0 and doutb holds its previous value.
- Collision (wena & renb & addra==addrb, same cycle):
  - WRITE_FIRST=0: doutb returns the pre-write word.
  - WRITE_FIRST=1: doutb returns the merged word (enabled bytes from dina, remaining bytes from the old word).
  - In both modes the array is updated normally.
- Read of an address written on the previous cycle always returns the new data in both modes.
- Address arithmetic is unsigned; the sweep counter is ADDR_W+1 bits wide so termination is detected without wrap-around.

Test Plan:
- CLEAR_ON_RESET=1, DEPTH=1024: release rst -> init_busy high for exactly 1024 cycles. Then read addresses 0, 5 and 1023 -> doutb=0 with rvalidb=1.
- Full-word writes: 350 to address 5 and 670 to address 7 (wbea=4'hF), then read 5 and 7 on consecutive cycles -> doutb=350 then 670. With READ_LATENCY=1, rvalidb is high for 2 consecutive cycles, each one cycle after the corresponding renb.
- Byte-enable write: word 5 holds 32'h11223344; write 32'hAABBCCDD with wbea=4'b0101 -> reading 5 returns 32'h11BB33DD.
- Collision at address 5 with old word 350, writing 961, wbea=4'hF: WRITE_FIRST=0 -> doutb=350 and a following read returns 961. WRITE_FIRST=1 -> doutb=961.
- READ_LATENCY=2: renb at cycle n -> rvalidb and the data appear at cycle n+2. Reads on three consecutive cycles -> three consecutive valid outputs.
- Reset mid-sweep and mid-read:
  - Assert rst at sweep count 300 -> sweep restarts and init_busy lasts 1024 cycles after release.
  - Assert rst while a read is in flight -> rvalidb=0 and doutb=0 immediately, with no late valid after release.
  - wena and renb issued during INIT -> no memory change and no rvalidb.
